// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP processor fetch path.
//   - Default widths for the program counter, instruction word and opcode.
//   - Opcode constants (opcode lives in the instruction MSBs).
//   - Encoding of the fetch FSM state.
// No ports; imported by bip_fetch_if, bip_pc and bip_fetch.
// -----------------------------------------------------------------------------
package bip_pkg;

  localparam int DEF_PC_WIDTH     = 11;
  localparam int DEF_INSTR_WIDTH  = 16;
  localparam int DEF_OPCODE_WIDTH = 5;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/bip_fetch_if.sv
// -----------------------------------------------------------------------------
// bip_fetch_if
// Bundles the fetch stage's start/handshake/memory signals.
//   master : the fetch stage (drives o_*, receives i_*)
//   slave  : the environment, i.e. control unit + instruction memory
// Signals:
//   i_start      start pulse, fetch from address 0
//   i_ready      control accepts o_instr
//   i_imem_data  synchronous memory read data (one cycle after enable)
//   o_imem_addr  memory read address
//   o_imem_en    memory read enable
//   o_instr      instruction to control
//   o_valid      o_instr is valid
//   o_pc         address of the presented instruction
//   o_halted     HLT accepted, fetch stopped
//   o_pc_wrap    sticky PC wrap flag
// -----------------------------------------------------------------------------
import bip_pkg::*;

interface bip_fetch_if #(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);
  logic                   i_start;
  logic                   i_ready;
  logic [INSTR_WIDTH-1:0] i_imem_data;
  logic [PC_WIDTH-1:0]    o_imem_addr;
  logic                   o_imem_en;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic                   o_valid;
  logic [PC_WIDTH-1:0]    o_pc;
  logic                   o_halted;
  logic                   o_pc_wrap;

  modport master (
    input  i_start, i_ready, i_imem_data,
    output o_imem_addr, o_imem_en, o_instr, o_valid, o_pc, o_halted, o_pc_wrap
  );

  modport slave (
    output i_start, i_ready, i_imem_data,
    input  o_imem_addr, o_imem_en, o_instr, o_valid, o_pc, o_halted, o_pc_wrap
  );
endinterface

// File: rtl/bip_pc.sv
// -----------------------------------------------------------------------------
// bip_pc
// Program counter register with clear, increment and a sticky wrap flag.
// Ports:
//   i_clock     clock
//   i_reset_n   asynchronous active-low reset
//   i_clear     pc <= 0, wrap flag cleared (priority over increment)
//   i_inc       pc <= pc + 1 (modulo 2^PC_WIDTH)
//   o_pc        current pc
//   o_pc_next   pc + 1, used for prefetch addressing
//   o_wrap      set when pc increments from all-ones to 0
// -----------------------------------------------------------------------------
import bip_pkg::*;

module bip_pc #(
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_inc,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_next,
  output logic                o_wrap
);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_wrap;
  logic [PC_WIDTH-1:0] w_pc_next;

  assign w_pc_next = r_pc + PC_WIDTH'(1);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc   <= '0;
      r_wrap <= 1'b0;
    end else if (i_clear) begin
      r_pc   <= '0;
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      r_pc <= w_pc_next;
      // Wrap is sticky: only a clear or reset drops it.
      if (&r_pc) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_pc_next = w_pc_next;
  assign o_wrap    = r_wrap;

endmodule

// File: rtl/bip_fetch.sv
// -----------------------------------------------------------------------------
// bip_fetch
// Instruction-fetch stage of the BIP processor. Owns the PC, reads 16-bit
// instructions from a synchronous instruction memory and presents them to
// the control unit through a valid/ready handshake. Fetch stops once a HLT
// instruction is accepted and restarts only on i_start.
//
// Build option: define BIP_FETCH_PREFETCH_EN to issue the next read in the
// same cycle a non-HLT instruction is accepted (one instruction per cycle).
// Without it, every accept goes back through REQ (one instruction per two
// cycles). Ports and reset behaviour are the same in both builds.
//
// Ports:
//   i_clock     clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   bus         bip_fetch_if.master: start, handshake and memory signals
// -----------------------------------------------------------------------------
import bip_pkg::*;

module bip_fetch #(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  bip_fetch_if.master bus
);

  fetch_state_e        r_state;
  logic                r_valid;
  logic                r_halted;

  logic                w_is_hlt;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_pc_inc;
  logic                w_prefetch;
  logic [PC_WIDTH-1:0] w_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic                w_wrap;

  // The memory holds its output while enable is low, so the opcode of the
  // presented instruction is read straight off the memory data.
  assign w_is_hlt   = (bus.i_imem_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] ==
                       OPCODE_WIDTH'(OP_HLT));
  assign w_accept   = (r_state == ST_VALID) && bus.i_ready;
  assign w_start_ok = bus.i_start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
  assign w_pc_inc   = w_accept && !w_is_hlt;

`ifdef BIP_FETCH_PREFETCH_EN
  // Next read is launched in the accept cycle so its data lands while the
  // FSM stays in VALID.
  assign w_prefetch = w_pc_inc;
`else
  assign w_prefetch = 1'b0;
`endif

  bip_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_start_ok),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc),
    .o_pc_next (w_pc_next),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_state <= ST_VALID;
          r_valid <= 1'b1;
        end
        ST_VALID: begin
          if (bus.i_ready) begin
            if (w_is_hlt) begin
              r_state  <= ST_HALT;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end else begin
`ifdef BIP_FETCH_PREFETCH_EN
              r_state <= ST_VALID;
`else
              r_state <= ST_REQ;
              r_valid <= 1'b0;
`endif
            end
          end
        end
        ST_HALT: begin
          if (bus.i_start) begin
            r_state  <= ST_REQ;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_imem_en   = (r_state == ST_REQ) || w_prefetch;
  assign bus.o_imem_addr = w_prefetch ? w_pc_next : w_pc;
  assign bus.o_instr     = bus.i_imem_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_pc        = w_pc;
  assign bus.o_halted    = r_halted;
  assign bus.o_pc_wrap   = w_wrap;

endmodule

// File: tb/tb_bip_fetch.sv
// -----------------------------------------------------------------------------
// tb_bip_fetch
// Self-checking bench for bip_fetch: a cycle table for the first program,
// a scoreboard of expected (pc, instr) pairs popped on every accept, and
// hand-written sequences for restart, back-pressure, throughput, PC wrap
// (separate PC_WIDTH=3 instance) and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
import bip_pkg::*;

module tb_bip_fetch;

  localparam int PCW  = 11;
  localparam int PCW3 = 3;
  localparam int IW   = 16;
`ifdef BIP_FETCH_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bip_fetch_if #(.PC_WIDTH(PCW),  .INSTR_WIDTH(IW)) bus  ();
  bip_fetch_if #(.PC_WIDTH(PCW3), .INSTR_WIDTH(IW)) bus3 ();

  bip_fetch #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .OPCODE_WIDTH(5)) u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  bip_fetch #(.PC_WIDTH(PCW3), .INSTR_WIDTH(IW), .OPCODE_WIDTH(5)) u_dut3 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus3)
  );

  logic [IW-1:0] mem  [0:(1<<PCW)-1];
  logic [IW-1:0] mem3 [0:(1<<PCW3)-1];

  // Synchronous instruction memories: data one cycle after an enabled read.
  always @(posedge clk) if (bus.o_imem_en)  bus.i_imem_data  <= mem[bus.o_imem_addr];
  always @(posedge clk) if (bus3.o_imem_en) bus3.i_imem_data <= mem3[bus3.o_imem_addr];

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
  } sb_t;

  typedef struct {
    logic           start;
    logic           ready;
    logic           exp_valid;
    logic           exp_halted;
    logic           exp_en;
    logic [PCW-1:0] exp_addr;
    logic [PCW-1:0] exp_pc;
  } vec_t;

  sb_t  sb_q[$];
  int   acc_cyc[$];
  vec_t tbl [8];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int pc, input logic [IW-1:0] instr);
    sb_t e;
    e.pc    = PCW'(pc);
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Called at a negedge with inputs set; records any handshake that the
  // coming rising edge completes, then advances to the next negedge.
  task automatic tick();
    sb_t e;
    if (bus.o_valid && bus.i_ready) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: accept at pc %0d instr 0x%0h with nothing expected",
                 bus.o_pc, bus.o_instr);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", 32'(bus.o_pc), 32'(e.pc));
        chk("sb_instr", 32'(bus.o_instr), 32'(e.instr));
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    for (int n = 0; n < budget && !bus.o_valid; n++) tick();
    chk("wait_valid", 32'(bus.o_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    bus.i_start  = 1'b0;
    bus.i_ready  = 1'b0;
    bus3.i_start = 1'b0;
    bus3.i_ready = 1'b0;
    for (int i = 0; i < (1<<PCW); i++) mem[i] = '0;
    for (int i = 0; i < (1<<PCW3); i++) mem3[i] = 16'h1801;

    // Reset values, checked before the first clock edge.
    #2;
    chk("rst_valid",  32'(bus.o_valid), 0);
    chk("rst_en",     32'(bus.o_imem_en), 0);
    chk("rst_addr",   32'(bus.o_imem_addr), 0);
    chk("rst_pc",     32'(bus.o_pc), 0);
    chk("rst_halted", 32'(bus.o_halted), 0);
    chk("rst_wrap",   32'(bus.o_pc_wrap), 0);
    chk("rst3_valid", 32'(bus3.o_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- program 0x1801, 0x2002, HLT with ready=1 ----------------
    mem[0] = 16'h1801; mem[1] = 16'h2002; mem[2] = 16'h0000;
    sb_push(0, 16'h1801); sb_push(1, 16'h2002); sb_push(2, 16'h0000);
`ifdef BIP_FETCH_PREFETCH_EN
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd1, 11'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd2, 11'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2, 11'd2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
`else
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd1, 11'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1, 11'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd2, 11'd2};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2, 11'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 11'd2};
`endif
    for (int i = 0; i < 8; i++) begin
      bus.i_start = tbl[i].start;
      bus.i_ready = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_valid", i),  32'(bus.o_valid),     32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_halted", i), 32'(bus.o_halted),    32'(tbl[i].exp_halted));
      chk($sformatf("tbl%0d_en", i),     32'(bus.o_imem_en),   32'(tbl[i].exp_en));
      chk($sformatf("tbl%0d_addr", i),   32'(bus.o_imem_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_pc", i),     32'(bus.o_pc),        32'(tbl[i].exp_pc));
    end
    chk("prog_accepts", acc_cnt, 3);
    chk("prog_sb_drained", sb_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_no_en", 32'(bus.o_imem_en), 0);
      chk("halt_stays", 32'(bus.o_halted), 1);
    end

    // ---------------- restart, ignored start, back-pressure ----------------
    sb_push(0, 16'h1801); sb_push(1, 16'h2002); sb_push(2, 16'h0000);
    bus.i_ready = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("restart_halted", 32'(bus.o_halted), 0);
    chk("restart_req_en", 32'(bus.o_imem_en), 1);
    chk("restart_req_valid", 32'(bus.o_valid), 0);
    tick();
    chk("restart_valid", 32'(bus.o_valid), 1);
    chk("restart_pc", 32'(bus.o_pc), 0);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    wait_valid(6);
    for (int i = 0; i < 5; i++) begin
      bus.i_start = (i == 2);
      tick();
      chk("bp_valid", 32'(bus.o_valid), 1);
      chk("bp_instr", 32'(bus.o_instr), 32'h2002);
      chk("bp_pc", 32'(bus.o_pc), 1);
      chk("bp_en", 32'(bus.o_imem_en), 0);
    end
    bus.i_start = 1'b0;
    n0 = acc_cnt;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_one_accept", acc_cnt - n0, 1);
    chk("bp_next_pc", 32'(bus.o_pc), 2);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6 && !bus.o_halted; i++) tick();
    chk("bp_halted", 32'(bus.o_halted), 1);
    chk("bp_sb_drained", sb_q.size(), 0);

    // ---------------- throughput: 8 non-HLT then HLT ----------------
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'h2000 | 16'(i);
      sb_push(i, 16'h2000 | 16'(i));
    end
    mem[8] = 16'h0000;
    sb_push(8, 16'h0000);
    acc_cyc.delete();
    bus.i_start = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 40 && !bus.o_halted; i++) tick();
    chk("tput_halted", 32'(bus.o_halted), 1);
    chk("tput_accepts", acc_cyc.size(), 9);
    if (acc_cyc.size() >= 8) begin
      for (int k = 1; k < 8; k++) chk("tput_gap", acc_cyc[k] - acc_cyc[k-1], GAP);
    end
    chk("tput_sb_drained", sb_q.size(), 0);

    // ---------------- PC wrap on the PC_WIDTH=3 instance ----------------
    bus3.i_start = 1'b1;
    bus3.i_ready = 1'b1;
    tick();
    bus3.i_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      if (bus3.o_valid) begin
        chk("wrap_pc", 32'(bus3.o_pc), n % 8);
        chk("wrap_flag", 32'(bus3.o_pc_wrap), (n >= 8) ? 1 : 0);
        chk("wrap_instr", 32'(bus3.o_instr), 32'h1801);
        n++;
      end
      tick();
    end
    chk("wrap_accepts", n, 10);
    chk("wrap_sticky", 32'(bus3.o_pc_wrap), 1);

    // ---------------- asynchronous reset in VALID at pc 4 ----------------
    for (int i = 0; i < 16; i++) mem[i] = 16'h2800 | 16'(i);
    for (int i = 0; i < 4; i++) sb_push(i, 16'h2800 | 16'(i));
    bus.i_start = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 40 && !(bus.o_valid && bus.o_pc == PCW'(4)); i++) tick();
    bus.i_ready = 1'b0;
    chk("mid_at_pc4", 32'(bus.o_pc), 4);
    chk("mid_valid", 32'(bus.o_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(bus.o_valid), 0);
    chk("arst_en",     32'(bus.o_imem_en), 0);
    chk("arst_addr",   32'(bus.o_imem_addr), 0);
    chk("arst_pc",     32'(bus.o_pc), 0);
    chk("arst_halted", 32'(bus.o_halted), 0);
    chk("arst_wrap3",  32'(bus3.o_pc_wrap), 0);
    chk("mid_sb_drained", sb_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_push(0, 16'h2800);
    bus.i_start = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_valid(4);
    chk("resume_pc", 32'(bus.o_pc), 0);
    tick();
    chk("resume_sb_drained", sb_q.size(), 0);
    bus.i_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bip_fetch.md
# bip_fetch

Instruction-fetch stage of the BIP processor, directly upstream of the control unit. Owns the program counter, reads 16-bit instructions from the synchronous instruction memory and presents them to control through a valid/ready handshake. Stops issuing fetches once a HLT instruction has been accepted, and restarts only on an explicit start pulse.

## Interface
- `PC_WIDTH`, 11: program counter and instruction-memory address width.
- `INSTR_WIDTH`, 16: instruction width.
- `OPCODE_WIDTH`, 5: opcode field width, taken from instruction MSBs.

Ports:
- `i_clock`  in  1  sole clock; all state changes on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse; begins fetching from address 0.
- `i_ready`  in  1  control accepts `o_instr` this cycle.
- `i_imem_data`  in  INSTR_WIDTH  memory read data, valid one cycle after an enabled read; held while enable is low.
- `o_imem_addr`  out  PC_WIDTH  memory read address.
- `o_imem_en`  out  1  memory read enable.
- `o_instr`  out  INSTR_WIDTH  instruction to control; equals `i_imem_data`.
- `o_valid`  out  1  `o_instr` is valid.
- `o_pc`  out  PC_WIDTH  address of the instruction currently presented.
- `o_halted`  out  1  HLT accepted; fetch stopped.
- `o_pc_wrap`  out  1  sticky; PC wrapped from all-ones to 0.

## Operation
- FSM states: IDLE, REQ, VALID, HALT.
- IDLE: reset state. `i_start` moves to REQ with pc=0 and clears `o_pc_wrap`.
- REQ: `o_imem_en`=1, `o_imem_addr`=pc. Always moves to VALID on the next cycle.
- VALID: `o_valid`=1.
  - If `i_ready`=0: stay in VALID with `o_imem_en`=0, so `o_instr` holds stable.
  - If `i_ready`=1 and the opcode is HLT (00000): move to HALT. pc is not incremented and no read is issued.
  - If `i_ready`=1 and the opcode is anything else: pc<=pc+1, then continue as set by `## Configuration`.
- HALT: `o_halted`=1 and `o_valid`=0. `i_start` moves to REQ with pc=0 and clears `o_pc_wrap`.
- `i_start` is ignored in REQ and VALID.
- PC arithmetic is modulo 2^PC_WIDTH. Incrementing from all-ones gives 0 and sets `o_pc_wrap`, which stays set until the next start or reset.
- `i_ready` is ignored whenever `o_valid`=0.

## Timing
- Reset values: state IDLE, pc 0, `o_valid` 0, `o_imem_en` 0, `o_imem_addr` 0, `o_halted` 0, `o_pc_wrap` 0. `o_instr` follows memory output and is don't-care while `o_valid`=0.
- Reset asserted mid-operation: state goes to IDLE immediately, without waiting for a clock edge. Any presented instruction is dropped.
- Start to first valid: `i_start` in cycle t, REQ in t+1, `o_valid`=1 in t+2.
- `o_valid`, `o_instr` and `o_pc` stay stable until the cycle in which `i_ready`=1.
- Without prefetch: sustained throughput is one instruction per 2 cycles.
- With prefetch: sustained throughput is one instruction per cycle.
- `o_halted` rises the cycle after the HLT handshake.

## Configuration
- Macro: `BIP_FETCH_PREFETCH_EN`.
- Defined: on a non-HLT accept in VALID, `o_imem_en`=1 and `o_imem_addr`=pc+1 in that same cycle. The FSM stays in VALID and the next instruction is valid the following cycle. REQ is entered only from IDLE or HALT.
- Undefined: a non-HLT accept moves to REQ. `o_imem_en` is 0 in every VALID cycle.
- Ports and reset behaviour are identical in both builds.

## Structure
- Shared package `bip_pkg` holds:
  - opcode constants: HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI;
  - `OPCODE_WIDTH`, `PC_WIDTH` and `INSTR_WIDTH` defaults;
  - the fetch FSM state encoding.
- Sub-module `bip_pc`: PC register with clear, increment and a wrap-flag output. Instantiated once.

## Test plan
- Reset then start; memory holds 0x1801, 0x2002, 0x0000; `i_ready`=1 throughout.
  - Required: 0x1801 at pc 0, then 0x2002 at pc 1, then 0x0000 at pc 2.
  - Then `o_halted`=1 and no further `o_imem_en`.
- Back-pressure: hold `i_ready`=0 for 5 cycles while 0x2002 is presented.
  - Required: `o_instr`, `o_pc` and `o_valid` unchanged for all 5 cycles, `o_imem_en`=0.
  - On release, exactly one accept.
- Throughput: 8 non-HLT instructions with `i_ready`=1.
  - Required: accepts every cycle with prefetch, every 2 cycles without.
- Wrap: PC_WIDTH=3, memory all 0x1801, run 10 accepts.
  - Required: pc sequence 0..7,0,1 and `o_pc_wrap`=1 from the first wrap.
- Reset mid-run: drop `i_reset_n` while in VALID at pc 4.
  - Required: outputs at reset values asynchronously; after start, fetch resumes at pc 0.
- Restart after halt: pulse `i_start` in HALT.
  - Required: `o_halted`=0 in the next cycle and first instruction valid 2 cycles after the pulse, at pc 0.
  - A start pulse during VALID is ignored.
